// File: rtl/kcpsm3_loader_pkg.sv
// Shared definitions for the kcpsm3 program-memory loader: FSM encoding,
// default sync marker, packet field offsets and the running-checksum helper.
package kcpsm3_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte offsets of the fields within a load packet
  localparam int OFS_SYNC    = 0;
  localparam int OFS_ADDR_HI = 1;
  localparam int OFS_ADDR_LO = 2;
  localparam int OFS_CNT_HI  = 3;
  localparam int OFS_CNT_LO  = 4;
  localparam int OFS_WORDS   = 5;
  localparam int WORD_BYTES  = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_CNT_HI  = 4'd3,
    ST_CNT_LO  = 4'd4,
    ST_W0      = 4'd5,
    ST_W1      = 4'd6,
    ST_W2      = 4'd7,
    ST_WRITE   = 4'd8,
    ST_CSUM    = 4'd9
  } loader_state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/kcpsm3_rom_loader_if.sv
// Byte-stream input, BRAM write port and status signals of the ROM loader.
interface kcpsm3_rom_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 18
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_WIDTH-1:0] ram_di;
  logic                  ram_we;
  logic                  cpu_reset;
  logic                  busy;
  logic                  load_done;
  logic                  load_error;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, ram_addr, ram_di, ram_we, cpu_reset, busy, load_done, load_error
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, ram_addr, ram_di, ram_we, cpu_reset, busy, load_done, load_error
  );
endinterface

// File: rtl/kcpsm3_loader_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and
// flags expiry on the last enabled cycle of the allowed window.
module kcpsm3_loader_timeout #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_r;

  // Down-counter holding the number of idle cycles still allowed
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CW'(CYCLES);
    end else if (clear) begin
      cnt_r <= CW'(CYCLES);
    end else if (enable && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && !clear && (cnt_r == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/kcpsm3_rom_loader.sv
// Decodes framed load packets from a byte stream into writes on the kcpsm3
// program BRAM, holding the processor in reset until a load checks out.
module kcpsm3_rom_loader
  import kcpsm3_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         ADDR_WIDTH     = 10,
  parameter int         WORD_WIDTH     = 18,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  kcpsm3_rom_loader_if.master bus
);

  localparam int AHI_W = ADDR_WIDTH - 8;
  localparam int WHI_W = WORD_WIDTH - 16;

  loader_state_t         state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [ADDR_WIDTH-1:0] rem_r, rem_s;
  logic [AHI_W-1:0]      hi_r, hi_s;
  logic [WHI_W-1:0]      w0_r, w0_s;
  logic [7:0]            w1_r, w1_s;
  logic [7:0]            sum_r, sum_s;
  logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_s;
  logic [WORD_WIDTH-1:0] ram_di_r, ram_di_s;
  logic ram_we_r, ram_we_s, rx_ready_r, rx_ready_s;
  logic cpu_reset_r, cpu_reset_s, busy_r, busy_s;
  logic load_done_r, load_done_s, load_error_r, load_error_s;
  logic accept_s, tmo_clear_s, tmo_enable_s, expired_s;

  assign accept_s     = bus.rx_valid && rx_ready_r;
  assign tmo_clear_s  = accept_s || (state_r == ST_IDLE);
  assign tmo_enable_s = (state_r != ST_IDLE) && (state_r != ST_WRITE);

  kcpsm3_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear_s),
    .enable  (tmo_enable_s),
    .expired (expired_s)
  );

  // Next-state and next-output logic; outputs are registered from state_s
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    rem_s        = rem_r;
    hi_s         = hi_r;
    w0_s         = w0_r;
    w1_s         = w1_r;
    sum_s        = sum_r;
    ram_addr_s   = ram_addr_r;
    ram_di_s     = ram_di_r;
    cpu_reset_s  = cpu_reset_r;
    load_done_s  = 1'b0;
    load_error_s = load_error_r;
    if (expired_s) begin
      state_s      = ST_IDLE;
      load_error_s = 1'b1;
    end else if (accept_s) begin
      sum_s = csum_add(sum_r, bus.rx_data);
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_s      = ST_ADDR_HI;
            sum_s        = 8'h00;
            cpu_reset_s  = 1'b1;
            load_error_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ADDR_HI: begin
          hi_s    = bus.rx_data[AHI_W-1:0];
          state_s = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_s  = {hi_r, bus.rx_data};
          state_s = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          hi_s    = bus.rx_data[AHI_W-1:0];
          state_s = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          // rem holds words still to write minus one
          rem_s   = {hi_r, bus.rx_data};
          state_s = ST_W0;
        end
        ST_W0: begin
          w0_s    = bus.rx_data[WHI_W-1:0];
          state_s = ST_W1;
        end
        ST_W1: begin
          w1_s    = bus.rx_data;
          state_s = ST_W2;
        end
        ST_W2: begin
          ram_addr_s = addr_r;
          ram_di_s   = {w0_r, w1_r, bus.rx_data};
          state_s    = ST_WRITE;
        end
        ST_CSUM: begin
          if (sum_s == 8'h00) begin
            load_done_s  = 1'b1;
            load_error_s = 1'b0;
            cpu_reset_s  = 1'b0;
          end else begin
            load_error_s = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if (state_r == ST_WRITE) begin
      addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (rem_r == {ADDR_WIDTH{1'b0}}) begin
        state_s = ST_CSUM;
      end else begin
        rem_s   = rem_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        state_s = ST_W0;
      end
    end else begin
      state_s = state_r;
    end
    rx_ready_s = (state_s != ST_WRITE);
    ram_we_s   = (state_s == ST_WRITE);
    busy_s     = (state_s != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      rem_r        <= {ADDR_WIDTH{1'b0}};
      hi_r         <= {AHI_W{1'b0}};
      w0_r         <= {WHI_W{1'b0}};
      w1_r         <= 8'h00;
      sum_r        <= 8'h00;
      ram_addr_r   <= {ADDR_WIDTH{1'b0}};
      ram_di_r     <= {WORD_WIDTH{1'b0}};
      ram_we_r     <= 1'b0;
      rx_ready_r   <= 1'b1;
      cpu_reset_r  <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      rem_r        <= rem_s;
      hi_r         <= hi_s;
      w0_r         <= w0_s;
      w1_r         <= w1_s;
      sum_r        <= sum_s;
      ram_addr_r   <= ram_addr_s;
      ram_di_r     <= ram_di_s;
      ram_we_r     <= ram_we_s;
      rx_ready_r   <= rx_ready_s;
      cpu_reset_r  <= cpu_reset_s;
      busy_r       <= busy_s;
      load_done_r  <= load_done_s;
      load_error_r <= load_error_s;
    end
  end

  assign bus.rx_ready   = rx_ready_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_di     = ram_di_r;
  assign bus.ram_we     = ram_we_r;
  assign bus.cpu_reset  = cpu_reset_r;
  assign bus.busy       = busy_r;
  assign bus.load_done  = load_done_r;
  assign bus.load_error = load_error_r;

endmodule
